// File: rtl/bsg_manycore_fpu_share_arb.sv
// rtl/bsg_manycore_fpu_share_arb.sv - two-tile shared FPU issue arbiter and result steering
// Optional statistics counters: BSG_MANYCORE_FPU_ARB_STATS_EN
module bsg_manycore_fpu_share_arb #(
  parameter int in_width_p     = 16,
  parameter int out_width_p    = 16,
  parameter int pipe_latency_p = 3,
  parameter int fifo_els_p     = 2
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [1:0]               req_v_i,
  input  logic [2*in_width_p-1:0]  req_data_i,
  output logic [1:0]               req_ready_o,
  output logic                     pipe_v_o,
  output logic [in_width_p-1:0]    pipe_data_o,
  input  logic                     pipe_v_i,
  input  logic [out_width_p-1:0]   pipe_data_i,
  output logic [1:0]               res_v_o,
  output logic [2*out_width_p-1:0] res_data_o,
  input  logic [1:0]               res_yumi_i
`ifdef BSG_MANYCORE_FPU_ARB_STATS_EN
  ,
  output logic [63:0]              grant_cnt_o,
  output logic [63:0]              stall_cnt_o
`endif
);

  localparam int cnt_w_lp = $clog2(fifo_els_p + 1);
  localparam int last_lp  = pipe_latency_p - 1;
  localparam logic [cnt_w_lp-1:0] full_lp = cnt_w_lp'(fifo_els_p);

  // credits: FIFO occupancy plus in-flight ops per tile
  logic [cnt_w_lp-1:0]       cnt_q [2];
  logic [cnt_w_lp-1:0]       cnt_d [2];
  logic                      last_grant_q, last_grant_d;
  logic [pipe_latency_p-1:0] tag_v_q, tag_v_d;
  logic [pipe_latency_p-1:0] tag_own_q, tag_own_d;
  logic [out_width_p-1:0]    mem_q [2][fifo_els_p];
  logic [out_width_p-1:0]    mem_d [2][fifo_els_p];
  logic [cnt_w_lp-1:0]       occ_q [2];
  logic [cnt_w_lp-1:0]       occ_d [2];

  logic [1:0] elig;
  logic [1:0] grant;
  logic       gnt_idx;

  // round-robin grant; blocked during reset so no accept is lost to the clear
  always_comb begin
    elig    = '0;
    gnt_idx = 1'b0;
    for (int i = 0; i < 2; i++) begin
      elig[i] = req_v_i[i] & (cnt_q[i] < full_lp) & ~reset_i;
    end
    if (&elig) gnt_idx = ~last_grant_q;
    else       gnt_idx = elig[1];
    grant       = {gnt_idx, ~gnt_idx} & {2{|elig}};
    req_ready_o = grant;
    pipe_v_o    = |grant;
    pipe_data_o = gnt_idx ? req_data_i[2*in_width_p-1:in_width_p]
                          : req_data_i[in_width_p-1:0];
  end

  // credit counters, last-grant pointer and owner tag pipeline
  always_comb begin
    last_grant_d = pipe_v_o ? gnt_idx : last_grant_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = cnt_q[i] + cnt_w_lp'(grant[i]) - cnt_w_lp'(res_yumi_i[i]);
    end
    tag_v_d      = '0;
    tag_own_d    = '0;
    tag_v_d[0]   = pipe_v_o;
    tag_own_d[0] = gnt_idx;
    for (int s = 1; s < pipe_latency_p; s++) begin
      tag_v_d[s]   = tag_v_q[s-1];
      tag_own_d[s] = tag_own_q[s-1];
    end
  end

  // per-tile result FIFOs kept head-aligned at slot 0; enqueue writes behind the post-dequeue tail
  always_comb begin
    logic                enq;
    logic                deq;
    logic [cnt_w_lp-1:0] wr;
    mem_d      = mem_q;
    res_v_o    = '0;
    res_data_o = '0;
    for (int i = 0; i < 2; i++) begin
      occ_d[i] = occ_q[i];
      enq = pipe_v_i & (tag_own_q[last_lp] == 1'(i));
      deq = res_yumi_i[i] & (occ_q[i] != '0);
      if (deq) begin
        for (int k = 0; k < fifo_els_p - 1; k++) begin
          mem_d[i][k] = mem_q[i][k+1];
        end
      end
      wr = occ_q[i] - cnt_w_lp'(deq);
      for (int k = 0; k < fifo_els_p; k++) begin
        if (enq && (wr == cnt_w_lp'(k))) mem_d[i][k] = pipe_data_i;
      end
      occ_d[i] = occ_q[i] + cnt_w_lp'(enq) - cnt_w_lp'(deq);
      res_v_o[i] = (occ_q[i] != '0);
      res_data_o[i*out_width_p +: out_width_p] = mem_q[i][0];
    end
  end

  // state registers; FIFO storage is data-only and needs no reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      last_grant_q <= 1'b1;
      tag_v_q      <= '0;
      tag_own_q    <= '0;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= '0;
        occ_q[i] <= '0;
      end
    end else begin
      last_grant_q <= last_grant_d;
      tag_v_q      <= tag_v_d;
      tag_own_q    <= tag_own_d;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= cnt_d[i];
        occ_q[i] <= occ_d[i];
      end
    end
    mem_q <= mem_d;
  end

`ifdef BSG_MANYCORE_FPU_ARB_STATS_EN
  logic [31:0] grant_cnt_q [2];
  logic [31:0] grant_cnt_d [2];
  logic [31:0] stall_cnt_q [2];
  logic [31:0] stall_cnt_d [2];

  // saturating accept and stall counters
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      grant_cnt_d[i] = grant_cnt_q[i];
      stall_cnt_d[i] = stall_cnt_q[i];
      if (grant[i] && (grant_cnt_q[i] != '1)) grant_cnt_d[i] = grant_cnt_q[i] + 32'd1;
      if (req_v_i[i] && !grant[i] && (stall_cnt_q[i] != '1)) stall_cnt_d[i] = stall_cnt_q[i] + 32'd1;
    end
    grant_cnt_o = {grant_cnt_q[1], grant_cnt_q[0]};
    stall_cnt_o = {stall_cnt_q[1], stall_cnt_q[0]};
  end

  // statistics registers
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 2; i++) begin
      if (reset_i) begin
        grant_cnt_q[i] <= '0;
        stall_cnt_q[i] <= '0;
      end else begin
        grant_cnt_q[i] <= grant_cnt_d[i];
        stall_cnt_q[i] <= stall_cnt_d[i];
      end
    end
  end
`endif

  // protocol checks: pipe return must match the tag pipeline, dequeue only when valid
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (pipe_v_i == tag_v_q[last_lp])
        else $error("pipe_v_i disagrees with last tag stage valid");
      for (int i = 0; i < 2; i++) begin
        assert (!(res_yumi_i[i] && !res_v_o[i]))
          else $error("res_yumi_i[%0d] while res_v_o low", i);
      end
    end
  end

endmodule

// File: tb/tb_bsg_manycore_fpu_share_arb.sv
// tb/tb_bsg_manycore_fpu_share_arb.sv - randomized self-checking bench with queue-based reference model
module tb_bsg_manycore_fpu_share_arb;

  localparam int IW = 16;
  localparam int OW = 16;
  localparam int L  = 3;
  localparam int F  = 2;

  logic            clk_i = 1'b0;
  logic            reset_i = 1'b1;
  logic [1:0]      req_v_i = '0;
  logic [2*IW-1:0] req_data_i = '0;
  logic [1:0]      req_ready_o;
  logic            pipe_v_o;
  logic [IW-1:0]   pipe_data_o;
  logic            pipe_v_i = 1'b0;
  logic [OW-1:0]   pipe_data_i = '0;
  logic [1:0]      res_v_o;
  logic [2*OW-1:0] res_data_o;
  logic [1:0]      res_yumi_i = '0;
`ifdef BSG_MANYCORE_FPU_ARB_STATS_EN
  logic [63:0]     grant_cnt_o;
  logic [63:0]     stall_cnt_o;
`endif

  bsg_manycore_fpu_share_arb #(
    .in_width_p(IW), .out_width_p(OW), .pipe_latency_p(L), .fifo_els_p(F)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req_v_i(req_v_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
    .pipe_v_o(pipe_v_o), .pipe_data_o(pipe_data_o),
    .pipe_v_i(pipe_v_i), .pipe_data_i(pipe_data_i),
    .res_v_o(res_v_o), .res_data_o(res_data_o), .res_yumi_i(res_yumi_i)
`ifdef BSG_MANYCORE_FPU_ARB_STATS_EN
    , .grant_cnt_o(grant_cnt_o), .stall_cnt_o(stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int            due;
    int            own;
    logic [OW-1:0] res;
  } flight_t;

  flight_t       pipe_q[$];
  logic [OW-1:0] fq0[$];
  logic [OW-1:0] fq1[$];
  int            gseq[$];
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_bad = 0;
  int            last_m = 1;
  int            acc[2];
  int            stl[2];
  int            first_res = -1;
  int            t_acc = 0;

  function automatic logic [OW-1:0] fpu_fn(input logic [IW-1:0] d);
    return {d[7:0], d[15:8]} ^ 16'h5a3c;
  endfunction

  function automatic int credits(input int i);
    int c;
    c = (i == 0) ? fq0.size() : fq1.size();
    foreach (pipe_q[k]) if (pipe_q[k].own == i) c++;
    return c;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [1:0] v, input logic [1:0] yw);
    logic [1:0] el;
    logic [1:0] eg;
    int         g;
    flight_t    e;
    @(negedge clk_i);
    reset_i       = 1'b0;
    req_v_i       = v;
    req_data_i    = $urandom;
    res_yumi_i[0] = yw[0] && (fq0.size() > 0);
    res_yumi_i[1] = yw[1] && (fq1.size() > 0);
    if (pipe_q.size() > 0 && pipe_q[0].due == cyc) begin
      pipe_v_i    = 1'b1;
      pipe_data_i = pipe_q[0].res;
    end else begin
      pipe_v_i    = 1'b0;
      pipe_data_i = OW'($urandom);
    end
    #1;
    for (int i = 0; i < 2; i++) el[i] = v[i] && (credits(i) < F);
    g = -1;
    if (el == 2'b11) g = 1 - last_m;
    else if (el[0])  g = 0;
    else if (el[1])  g = 1;
    eg = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);
    chk("req_ready", 64'(req_ready_o), 64'(eg));
    chk("pipe_v", 64'(pipe_v_o), 64'(g >= 0));
    if (g >= 0) chk("pipe_data", 64'(pipe_data_o), 64'(req_data_i[g*IW +: IW]));
    chk("res_v", 64'(res_v_o), {62'd0, fq1.size() > 0, fq0.size() > 0});
    if (fq0.size() > 0) chk("res_data0", 64'(res_data_o[OW-1:0]), 64'(fq0[0]));
    if (fq1.size() > 0) chk("res_data1", 64'(res_data_o[2*OW-1:OW]), 64'(fq1[0]));
    if (res_v_o[0] && first_res < 0) first_res = cyc;
    if (res_yumi_i[0]) void'(fq0.pop_front());
    if (res_yumi_i[1]) void'(fq1.pop_front());
    if (pipe_v_i) begin
      if (pipe_q[0].own == 0) fq0.push_back(pipe_q[0].res);
      else                    fq1.push_back(pipe_q[0].res);
      void'(pipe_q.pop_front());
    end
    for (int i = 0; i < 2; i++) if (v[i] && g != i) stl[i]++;
    if (g >= 0) begin
      e.due = cyc + L;
      e.own = g;
      e.res = fpu_fn(req_data_i[g*IW +: IW]);
      pipe_q.push_back(e);
      last_m = g;
      acc[g]++;
      gseq.push_back(g);
    end
    cyc++;
  endtask

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk_i);
      reset_i     = 1'b1;
      req_v_i     = '0;
      res_yumi_i  = '0;
      pipe_v_i    = 1'b1;
      pipe_data_i = OW'($urandom);
      cyc++;
    end
    pipe_q.delete();
    fq0.delete();
    fq1.delete();
    gseq.delete();
    last_m = 1;
    acc    = '{0, 0};
    stl    = '{0, 0};
    @(negedge clk_i);
    reset_i    = 1'b0;
    req_v_i    = '0;
    res_yumi_i = '0;
    pipe_v_i   = 1'b0;
    #1;
    chk("rst_ready", 64'(req_ready_o), 64'd0);
    chk("rst_pipe_v", 64'(pipe_v_o), 64'd0);
    chk("rst_res_v", 64'(res_v_o), 64'd0);
    cyc++;
  endtask

  initial begin
    acc = '{0, 0};
    stl = '{0, 0};
    do_reset(2);

    // single tile 0 request: result visible pipe_latency_p+1 cycles after accept
    t_acc = cyc;
    first_res = -1;
    step(2'b01, 2'b00);
    chk("single_accept", 64'(acc[0]), 64'd1);
    for (int k = 0; k < 6; k++) step(2'b00, 2'b01);
    chk("latency", 64'(first_res - t_acc), 64'(L + 1));

    // contention from reset: tile 0 first, then alternate
    do_reset(1);
    for (int k = 0; k < 4; k++) step(2'b11, 2'b11);
    chk("alternate", {gseq[0][15:0], gseq[1][15:0], gseq[2][15:0], gseq[3][15:0]},
        {16'd0, 16'd1, 16'd0, 16'd1});
    for (int k = 0; k < 16; k++) step(2'b11, 2'b11);

    // tile 1 never dequeues: credits cap it at fifo_els_p accepts
    do_reset(1);
    for (int k = 0; k < 20; k++) step(2'b11, 2'b01);
    chk("t1_capped", 64'(acc[1]), 64'(F));
    chk("t1_ready_low", 64'(req_ready_o[1]), 64'd0);
    step(2'b11, 2'b11);
    for (int k = 0; k < 15; k++) step(2'b11, 2'b01);
    chk("t1_one_more", 64'(acc[1]), 64'(F + 1));

`ifdef BSG_MANYCORE_FPU_ARB_STATS_EN
    do_reset(1);
    for (int k = 0; k < 10; k++) step(2'b11, 2'b11);
    @(posedge clk_i);
    #1;
    chk("grant_cnt", grant_cnt_o, {32'(acc[1]), 32'(acc[0])});
    chk("stall_cnt", stall_cnt_o, {32'(stl[1]), 32'(stl[0])});
`endif

    // reset with ops in flight: everything cleared, tile 0 wins next conflict
    do_reset(1);
    for (int k = 0; k < 3; k++) step(2'b11, 2'b00);
    do_reset(1);
    step(2'b11, 2'b11);
    chk("post_rst_grant", 64'(gseq[0]), 64'd0);
    for (int k = 0; k < 8; k++) step(2'b00, 2'b11);

    // randomized traffic
    for (int k = 0; k < 300; k++) step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    for (int k = 0; k < 10; k++) step(2'b00, 2'b11);
    chk("drained", 64'(res_v_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
